multdiv_ctrl: RTL and testbench
===============================

Name: multdiv_ctrl

Overview:
- Sequencer between the main control unit and the iterative mult/div datapath.
- Accepts one MULT or DIV request at a time and issues the single-cycle start strobe to the selected unit.
- Counts the unit's fixed iteration latency, then emits HI/LO write enables and a done pulse.
- Holds busy for control-unit stalling; traps divide-by-zero before starting the divider.

Parameters:
- MULT_CYCLES, 32: cycles spent in WAIT after the mult start strobe, before HI/LO are valid.
- DIV_CYCLES, 32: cycles spent in WAIT after the div start strobe, before HI/LO are valid.
- CNT_W, 6: down-counter width; must hold max(MULT_CYCLES, DIV_CYCLES).
- CHECK_DIV0, 1: 1 = trap divisor==0 at accept; 0 = start the divider regardless.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mult_req  in  1  control unit requests MULT; level, sampled only in IDLE.
- div_req  in  1  control unit requests DIV; level, sampled only in IDLE.
- divisor  in  32  regB_out value, checked for zero at accept.
- mult_control  out  1  one-cycle start strobe to the multiplier.
- div_control  out  1  one-cycle start strobe to the divider.
- hilo_sel  out  1  HI/LO input mux select: 0 = mult results, 1 = div results.
- hi_write  out  1  HI register load enable.
- lo_write  out  1  LO register load enable.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse on a successful HI/LO write.
- div_zero  out  1  one-cycle pulse when a DIV is rejected because divisor==0.

Behaviour:
- States: IDLE, START, WAIT, WRITE, DIVZ. State, counter, op and hilo_sel are registered; outputs are decoded from state.
- Reset: state=IDLE, counter=0, op=mult, hilo_sel=0. All outputs are 0 in the cycle after the reset edge.
- IDLE:
  - mult_req=1 -> START, op=mult. mult has priority: if div_req is high at the same edge it is ignored.
  - div_req=1 and mult_req=0 and (CHECK_DIV0=0 or divisor!=0) -> START, op=div.
  - div_req=1 and mult_req=0 and CHECK_DIV0=1 and divisor==0 -> DIVZ.
  - Otherwise stay in IDLE.
- START:
  - Exactly one cycle.
  - mult_control=1 if op=mult, else div_control=1.
  - counter loads MULT_CYCLES-1 or DIV_CYCLES-1; next state WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When counter==0 -> WRITE, so WAIT lasts exactly N cycles (N = the selected *_CYCLES).
  - No start strobe is driven in WAIT.
- WRITE:
  - Exactly one cycle: hi_write=1, lo_write=1, done=1; next state IDLE.
  - hilo_sel is driven by op and held from START through WRITE; it keeps its last value in IDLE.
- DIVZ:
  - Exactly one cycle: div_zero=1, done=0, no start strobe, no HI/LO write; next state IDLE.
- Latency: request sampled at edge E0.
  - START occupies cycle 1.
  - WAIT occupies cycles 2..N+1.
  - WRITE occupies cycle N+2.
  - busy is high for cycles 1..N+2; it is 0 in the accept cycle itself.
- Requests while busy: ignored, never queued.
  - The control unit must drop its request on the edge that ends WRITE or DIVZ.
  - A request still high in IDLE afterwards is treated as a new operation.
- Reset mid-operation (any state): return to IDLE next edge; no write and no done is emitted. The datapath units are reset by the same reset.
- Counter never underflows; in IDLE it holds its value.

Decomposition:
- Shared package mdu_pkg:
  - state enum: IDLE, START, WAIT, WRITE, DIVZ.
  - op enum: OP_MULT=0, OP_DIV=1.
  - default cycle constants.
- Single flat module; no sub-module is warranted.

Test Plan:
- Reset: assert reset for 2 cycles in WAIT of an active mult -> next cycle state IDLE, all outputs 0, and no hi_write/done afterwards.
- Mult request: mult_req pulses at E0 with defaults.
  - mult_control=1 in cycle 1 only; busy=1 in cycles 1..34.
  - hi_write=lo_write=done=1 in cycle 34 only; hilo_sel=0.
- Div request: div_req at E0 with divisor=7.
  - div_control=1 in cycle 1; hilo_sel=1 in cycles 1..34.
  - Writes and done in cycle 34; mult_control stays 0 throughout.
- Divide by zero: div_req with divisor=0, CHECK_DIV0=1.
  - div_zero=1 in cycle 1 only; no strobe, no write, busy=1 only in cycle 1.
  - Repeat with CHECK_DIV0=0: the divider starts normally.
- Simultaneous and busy requests:
  - mult_req=div_req=1 at E0 -> mult sequence, hilo_sel=0.
  - div_req raised in cycle 10 of the mult -> ignored, only one done pulse.
- Back-to-back: second mult_req raised in the cycle after WRITE -> new START the following cycle with identical 34-cycle timing; MULT_CYCLES=4 override gives done in cycle 6.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and default timing for the mult/div sequencer.
// Both the control block and the bench pull their state/op names from here.
package mdu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT,
      WRITE,
      DIVZ
   } state_e;

   typedef enum logic {
      OP_MULT = 1'b0,
      OP_DIV  = 1'b1
   } op_e;

   localparam int DEF_MULT_CYCLES = 32;
   localparam int DEF_DIV_CYCLES  = 32;
   localparam int DEF_CNT_W       = 6;

endpackage

// File: rtl/multdiv_ctrl.sv
// Sequencer that launches one MULT or DIV on the iterative datapath, waits out its
// fixed latency, then pulses the HI/LO write enables; divide-by-zero is trapped up front.
module multdiv_ctrl
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int CHECK_DIV0  = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        mult_req,
   input  logic        div_req,
   input  logic [31:0] divisor,
   output logic        mult_control,
   output logic        div_control,
   output logic        hilo_sel,
   output logic        hi_write,
   output logic        lo_write,
   output logic        busy,
   output logic        done,
   output logic        div_zero
);

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hilo_q, hilo_d;

   // hilo_sel is set at accept so the mux already points at the right unit during START.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      hilo_d  = hilo_q;
      case (state_q)
         IDLE: begin
            if (mult_req) begin
               state_d = START;
               op_d    = OP_MULT;
               hilo_d  = 1'b0;
            end else if (div_req) begin
               if ((CHECK_DIV0 != 0) && (divisor == 32'd0)) begin
                  state_d = DIVZ;
               end else begin
                  state_d = START;
                  op_d    = OP_DIV;
                  hilo_d  = 1'b1;
               end
            end
         end
         START: begin
            cnt_d   = (op_q == OP_MULT) ? MULT_LOAD : DIV_LOAD;
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = WRITE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WRITE:   state_d = IDLE;
         DIVZ:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next-state decode so they line up with the state they belong to.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         op_q         <= OP_MULT;
         cnt_q        <= '0;
         hilo_q       <= 1'b0;
         mult_control <= 1'b0;
         div_control  <= 1'b0;
         hi_write     <= 1'b0;
         lo_write     <= 1'b0;
         done         <= 1'b0;
         div_zero     <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         cnt_q        <= cnt_d;
         hilo_q       <= hilo_d;
         mult_control <= (state_d == START) && (op_d == OP_MULT);
         div_control  <= (state_d == START) && (op_d == OP_DIV);
         hi_write     <= (state_d == WRITE);
         lo_write     <= (state_d == WRITE);
         done         <= (state_d == WRITE);
         div_zero     <= (state_d == DIVZ);
         busy         <= (state_d != IDLE);
      end
   end

   assign hilo_sel = hilo_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Bench for multdiv_ctrl: two instances (defaults, and short latencies with the div0 trap off)
// share one stimulus stream and are compared every cycle against a timeline model.
module tb_multdiv_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        mult_req = 1'b0;
   logic        div_req = 1'b0;
   logic [31:0] divisor = 32'd0;

   logic mc [2];
   logic dc [2];
   logic hs [2];
   logic hw [2];
   logic lw [2];
   logic bz [2];
   logic dn [2];
   logic dz [2];

   int  checks = 0;
   int  errors = 0;
   bit  checkEn = 1'b0;

   always #5 clock = ~clock;

   multdiv_ctrl dut0 (
      .clock(clock), .reset(reset), .mult_req(mult_req), .div_req(div_req), .divisor(divisor),
      .mult_control(mc[0]), .div_control(dc[0]), .hilo_sel(hs[0]), .hi_write(hw[0]),
      .lo_write(lw[0]), .busy(bz[0]), .done(dn[0]), .div_zero(dz[0])
   );

   multdiv_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(5), .CNT_W(6), .CHECK_DIV0(0)) dut1 (
      .clock(clock), .reset(reset), .mult_req(mult_req), .div_req(div_req), .divisor(divisor),
      .mult_control(mc[1]), .div_control(dc[1]), .hilo_sel(hs[1]), .hi_write(hw[1]),
      .lo_write(lw[1]), .busy(bz[1]), .done(dn[1]), .div_zero(dz[1])
   );

   // Model: an operation is a timeline of cycles 1..last counted from its accept edge.
   int multLat [2] = '{32, 4};
   int divLat  [2] = '{32, 5};
   bit trapZero[2] = '{1'b1, 1'b0};
   bit active  [2] = '{1'b0, 1'b0};
   int kind    [2] = '{0, 0};
   int age     [2] = '{0, 0};
   bit lastSel [2] = '{1'b0, 1'b0};

   function automatic int lastCycle(input int i);
      if (kind[i] == 2) return 1;
      return ((kind[i] == 0) ? multLat[i] : divLat[i]) + 2;
   endfunction

   always @(posedge clock) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            active[i]  = 1'b0;
            lastSel[i] = 1'b0;
         end else if (active[i]) begin
            if (age[i] == lastCycle(i)) active[i] = 1'b0;
            else age[i] = age[i] + 1;
         end else if (mult_req) begin
            active[i] = 1'b1; kind[i] = 0; age[i] = 1; lastSel[i] = 1'b0;
         end else if (div_req) begin
            active[i] = 1'b1; age[i] = 1;
            if (trapZero[i] && divisor == 32'd0) begin
               kind[i] = 2;
            end else begin
               kind[i] = 1; lastSel[i] = 1'b1;
            end
         end
      end
      if (reset) checkEn = 1'b1;
   end

   task automatic checkOutput(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   // Per-cycle comparison of every output of both instances against the model.
   always @(negedge clock) begin
      if (checkEn) begin
         for (int i = 0; i < 2; i++) begin
            bit strobe, wr, zr;
            strobe = active[i] && kind[i] != 2 && age[i] == 1;
            wr     = active[i] && kind[i] != 2 && age[i] == lastCycle(i);
            zr     = active[i] && kind[i] == 2;
            checkOutput($sformatf("dut%0d.mult_control", i), mc[i], strobe && kind[i] == 0);
            checkOutput($sformatf("dut%0d.div_control", i),  dc[i], strobe && kind[i] == 1);
            checkOutput($sformatf("dut%0d.hilo_sel", i),     hs[i], lastSel[i]);
            checkOutput($sformatf("dut%0d.hi_write", i),     hw[i], wr);
            checkOutput($sformatf("dut%0d.lo_write", i),     lw[i], wr);
            checkOutput($sformatf("dut%0d.done", i),         dn[i], wr);
            checkOutput($sformatf("dut%0d.div_zero", i),     dz[i], zr);
            checkOutput($sformatf("dut%0d.busy", i),         bz[i], active[i]);
         end
      end
   end

   task automatic applyStimulus(input bit m, input bit d, input logic [31:0] dv, input bit r);
      @(negedge clock);
      #1;
      mult_req = m;
      div_req  = d;
      divisor  = dv;
      reset    = r;
   endtask

   int doneCount;

   initial begin
      $display("[TB] start");
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0);
      checkOutput("reset.busy", bz[0], 1'b0);
      checkOutput("reset.hilo_sel", hs[0], 1'b0);

      // Plain mult, default and short latency.
      applyStimulus(1, 0, 0, 0);
      for (int k = 1; k <= 36; k++) begin
         applyStimulus(0, 0, 0, 0);
         if (k == 1)  checkOutput("mult.strobe_c1", mc[0], 1'b1);
         if (k == 2)  checkOutput("mult.strobe_c2", mc[0], 1'b0);
         if (k == 6)  checkOutput("mult.short_done_c6", dn[1], 1'b1);
         if (k == 33) checkOutput("mult.done_c33", dn[0], 1'b0);
         if (k == 34) checkOutput("mult.done_c34", dn[0], 1'b1);
         if (k == 34) checkOutput("mult.hi_write_c34", hw[0], 1'b1);
         if (k == 34) checkOutput("mult.busy_c34", bz[0], 1'b1);
         if (k == 35) checkOutput("mult.busy_c35", bz[0], 1'b0);
      end

      // Div with a nonzero divisor.
      applyStimulus(0, 1, 32'd7, 0);
      for (int k = 1; k <= 36; k++) begin
         applyStimulus(0, 0, 0, 0);
         if (k == 1)  checkOutput("div.strobe_c1", dc[0], 1'b1);
         if (k == 1)  checkOutput("div.hilo_sel_c1", hs[0], 1'b1);
         if (k == 34) checkOutput("div.done_c34", dn[0], 1'b1);
      end

      // Divide by zero: trapped on dut0, started on dut1.
      applyStimulus(0, 1, 32'd0, 0);
      for (int k = 1; k <= 10; k++) begin
         applyStimulus(0, 0, 0, 0);
         if (k == 1) checkOutput("divz.div_zero_c1", dz[0], 1'b1);
         if (k == 1) checkOutput("divz.busy_c1", bz[0], 1'b1);
         if (k == 2) checkOutput("divz.busy_c2", bz[0], 1'b0);
         if (k == 1) checkOutput("divz.nocheck_strobe_c1", dc[1], 1'b1);
      end

      // Simultaneous requests: mult wins.
      applyStimulus(1, 1, 32'd3, 0);
      for (int k = 1; k <= 36; k++) begin
         applyStimulus(0, 0, 0, 0);
         if (k == 1) checkOutput("both.mult_strobe_c1", mc[0], 1'b1);
         if (k == 1) checkOutput("both.hilo_sel_c1", hs[0], 1'b0);
      end

      // Div request while busy is ignored.
      doneCount = 0;
      applyStimulus(1, 0, 0, 0);
      for (int k = 1; k <= 40; k++) begin
         applyStimulus(0, (k == 10), 32'd9, 0);
         if (dn[0]) doneCount++;
      end
      checkOutput("busy.single_done", doneCount == 1, 1'b1);

      // Reset in WAIT: no write or done afterwards.
      doneCount = 0;
      applyStimulus(1, 0, 0, 0);
      for (int k = 1; k <= 45; k++) begin
         applyStimulus(0, 0, 0, (k == 10 || k == 11));
         if (dn[0] || hw[0]) doneCount++;
         if (k == 12) checkOutput("rstmid.busy_c12", bz[0], 1'b0);
      end
      checkOutput("rstmid.no_done", doneCount == 0, 1'b1);

      // Back-to-back: new mult raised in the cycle after WRITE.
      applyStimulus(1, 0, 0, 0);
      for (int k = 1; k <= 72; k++) begin
         applyStimulus((k == 35), 0, 0, 0);
         if (k == 36) checkOutput("b2b.strobe_c36", mc[0], 1'b1);
         if (k == 69) checkOutput("b2b.done_c69", dn[0], 1'b1);
      end

      // Randomized traffic against the model.
      for (int k = 0; k < 2500; k++) begin
         applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0,
                       ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom),
                       $urandom_range(0, 299) == 0);
      end
      applyStimulus(0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
